// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional FAST_MUL_EN: multiplies complete in one cycle through a combinational multiplier.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      o_dbg_state
);

  // Handshake: an op is taken only when IDLE, start=1 and flush=0; there is no
  // backpressure on the result side, result_valid is a single-cycle pulse in DONE.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic            w_accept, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div_zero, w_div_ovf, w_special, w_last;
  logic [XLEN-1:0] w_special_res;

  assign w_accept   = (r_state == IDLE) && start && !flush;
  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed && operand_a[XLEN-1];
  assign w_b_neg    = w_b_signed && operand_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag    = w_b_neg ? -operand_b : operand_b;
  // Remainders follow the dividend sign; products and quotients use the sign XOR.
  assign w_neg      = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero    = w_is_div && (operand_b == '0);
  assign w_div_ovf     = w_is_div && !funct3[0] && (operand_a == MIN_NEG) && (operand_b == '1);
  assign w_special     = w_div_zero || w_div_ovf;
  assign w_special_res = w_div_zero ? (funct3[1] ? operand_a : '1)
                                    : (funct3[1] ? '0 : MIN_NEG);

  // One multiply step: add the multiplicand into the upper half, shift right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_mul_res;
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // One restoring-divide step on the 33-bit shifted partial remainder.
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_div_raw, w_div_res, w_calc_res;
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_b};
  assign w_qbit     = !w_diff[XLEN+1];
  assign w_rem_nxt  = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt  = {r_quo[XLEN-2:0], w_qbit};
  assign w_div_raw  = r_funct3[1] ? w_rem_nxt : w_quo_nxt;
  assign w_div_res  = r_neg ? -w_div_raw : w_div_raw;
  assign w_calc_res = r_funct3[2] ? w_div_res : w_mul_res;
  assign w_last     = (r_cnt == CNT_W'(XLEN-1));

`ifdef FAST_MUL_EN
  // 33-bit signed operands sign-extended to 64 bits; the low 64 product bits are exact.
  logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_fast;
  logic [XLEN-1:0]   w_fast_res;
  assign w_a_ext    = {{XLEN{w_a_neg}}, operand_a};
  assign w_b_ext    = {{XLEN{w_b_neg}}, operand_b};
  assign w_fast     = w_a_ext * w_b_ext;
  assign w_fast_res = (funct3[1:0] == 2'b00) ? w_fast[XLEN-1:0] : w_fast[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_funct3 <= funct3;
            r_rd     <= rd_in;
            r_a      <= w_a_mag;
            r_b      <= w_b_mag;
            r_neg    <= w_neg;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            if (w_special) begin
              r_result <= w_special_res;
              r_rd_out <= rd_in;
              r_state  <= DONE;
`ifdef FAST_MUL_EN
            end else if (!w_is_div) begin
              r_result <= w_fast_res;
              r_rd_out <= rd_in;
              r_state  <= DONE;
`endif
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_funct3[2]) begin
              r_rem <= w_rem_nxt;
              r_quo <= w_quo_nxt;
            end else begin
              r_acc <= w_acc_nxt;
              r_b   <= r_b >> 1;
            end
            if (w_last) begin
              r_result <= w_calc_res;
              r_rd_out <= r_rd;
              r_state  <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE) && !flush;
  assign result       = r_result;
  assign rd_out       = r_rd_out;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, flush/ignore/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in), .flush(flush),
    .busy(busy), .result_valid(result_valid), .result(result), .rd_out(rd_out),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    if (!f3[2]) return MUL_LAT;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // driver: issue one op and observe it to completion (bounded to 40 cycles)
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int pulses, output int busy_err);
    @(negedge clk);
    funct3 = f3; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom; rd_in = 5'($urandom);
    lat = -1; pulses = 0; busy_err = 0; res = '0; rdo = '0;
    for (int i = 1; i <= 40; i++) begin
      if (result_valid) begin
        pulses++;
        if (lat < 0) begin lat = i; res = result; rdo = rd_out; end
      end
      if (lat > 0 && i > lat) begin
        if (busy) busy_err++;
        break;
      end
      if (!busy) busy_err++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] res;
    logic [4:0]  rdo, rd;
    logic [2:0]  f3;
    logic [31:0] a, b, e;
    int lat, pulses, busy_err;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, MUL_LAT};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, MUL_LAT};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,        32'd14,       33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,        32'd2,        33};
    vecs[8]  = '{3'd5, 32'h1234,       32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd7, 32'h1234,       32'd0,        32'h1234,     1};
    vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{3'd4, 32'd55,         32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, MUL_LAT};

    reset_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0;
    operand_a = '0; operand_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", {27'd0, rd_out}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1'b1;

    // directed table
    for (int v = 0; v < 14; v++) begin
      rd = 5'(v + 1);
      run_op(vecs[v].f3, vecs[v].a, vecs[v].b, rd, res, rdo, lat, pulses, busy_err);
      chk($sformatf("vec%0d_result", v), res, vecs[v].exp);
      chk($sformatf("vec%0d_rd", v), {27'd0, rdo}, {27'd0, rd});
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("vec%0d_pulses", v), 32'(pulses), 32'd1);
      chk($sformatf("vec%0d_busy", v), 32'(busy_err), 32'd0);
    end

    // flush in CALC: busy drops next cycle, no pulse through N+40
    @(negedge clk);
    funct3 = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      if (result_valid) pulses++;
      if (k == 10) flush = 1'b1;
      if (k == 11) begin
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
      end
      @(negedge clk);
    end
    chk("flush_no_pulse", 32'(pulses), 32'd0);

    // start while busy is ignored; original rd_out and result survive
    funct3 = 3'd5; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; lat = -1; res = '0; rdo = '0;
    for (int k = 1; k <= 36; k++) begin
      if (result_valid) begin
        pulses++;
        if (lat < 0) begin lat = k; res = result; rdo = rd_out; end
      end
      if (k == 5) begin start = 1'b1; rd_in = 5'd9; funct3 = 3'd0; operand_a = 32'd2; end
      if (k == 6) start = 1'b0;
      if (k == 34) chk("ignore_idle_after", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    chk("ignore_result", res, 32'd333);
    chk("ignore_rd", {27'd0, rdo}, 32'd12);
    chk("ignore_latency", 32'(lat), 32'd33);
    chk("ignore_pulses", 32'(pulses), 32'd1);

    // reset in the middle of a multiply
    funct3 = 3'd0; operand_a = 32'd5; operand_b = 32'd6; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      if (k == 20) reset_n = 1'b0;
      if (k == 21) begin
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_valid", {31'd0, result_valid}, 32'd0);
        chk("midreset_result", result, 32'd0);
        chk("midreset_rd", {27'd0, rd_out}, 32'd0);
        reset_n = 1'b1;
      end
      if (k < 21) @(negedge clk);
    end
    a = $urandom; b = $urandom;
    run_op(3'd0, a, b, 5'd21, res, rdo, lat, pulses, busy_err);
    chk("postreset_result", res, ref_model(3'd0, a, b));
    chk("postreset_latency", 32'(lat), 32'(MUL_LAT));
    chk("postreset_rd", {27'd0, rdo}, 32'd21);

    // randomized ops through the scoreboard queue
    for (int n = 0; n < 150; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      exp_q.push_back(ref_model(f3, a, b));
      run_op(f3, a, b, rd, res, rdo, lat, pulses, busy_err);
      e = exp_q.pop_front();
      chk($sformatf("rand%0d_f%0d_%h_%h_result", n, f3, a, b), res, e);
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_lat(f3, a, b)));
      chk($sformatf("rand%0d_rd", n), {27'd0, rdo}, {27'd0, rd});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Sits in the EX stage beside the single-cycle ALU. It consumes R-type instructions with funct7=0000001 that the decoder flags as M-extension.
- Holds the pipeline via busy until its result is ready, then returns the result and destination register to the EX/MEM register.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  issue request, sampled only in IDLE
funct3  input  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  32  rs1 value
operand_b  input  32  rs2 value
rd_in  input  5  destination register of issued op
flush  input  1  kill in-flight op (branch/jump redirect)
busy  output  1  unit occupied; hazard unit stalls IF/ID/EX while high
result_valid  output  1  one-cycle pulse, result/rd_out valid
result  output  32  op result
rd_out  output  5  destination register of completed op

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset_n). Sampled on clk rising edge only.
- Reset values: state=IDLE, busy=0, result_valid=0, result=0, rd_out=0, all internal registers=0.
- States: IDLE, CALC, DONE.
- busy = (state != IDLE), registered-state decode.
- Accept rule: IDLE and start=1 and flush=0. On accept:
  - Latch funct3 and rd_in.
  - Latch magnitude of each operand. Sign is honoured per op: a is signed for MULH/MULHSU/DIV/REM; b is signed for MULH/DIV/REM.
  - Latch the result sign flags.
  - Clear the counter.
- Divide special cases are decided at accept time and go IDLE->DONE directly:
  - Divide by zero (b==0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand_a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Otherwise IDLE->CALC.
- CALC runs exactly 32 cycles, one bit per cycle, counter 0..31. Counter==31 moves to DONE.
- Multiply in CALC: shift-add over a 64-bit accumulator. If the product-sign flag is set, take the two's complement of the 64-bit product at the end.
  - MUL returns [31:0].
  - MULH, MULHSU and MULHU return [63:32].
- Divide in CALC: restoring radix-2 with a 33-bit partial remainder.
  - Quotient is negated if operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- DONE lasts one cycle:
  - result_valid=1; result and rd_out are driven.
  - Next state is IDLE. A start in DONE is ignored, so back-to-back issue costs one IDLE cycle.
- result and rd_out hold their last value after the pulse.
- Latency, start sampled at cycle N:
  - Normal ops: result_valid at N+33.
  - Special-case divides: result_valid at N+1.
- Operand inputs are don't-care after accept; the unit works on latched copies only.
- start while busy: ignored, no state change.
- flush in CALC or DONE: next state IDLE, no result_valid pulse (DONE suppresses the pulse combinationally when flush=1), busy low the next cycle.
- flush together with start in IDLE: not accepted.
- reset_n low in any state: back to IDLE at that edge with reset values; any in-flight op is discarded.

Optional Feature:
- FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 33x33 signed multiplier at accept time and go IDLE->DONE.
  - result_valid at N+1.
  - Divides are unchanged.
- FAST_MUL_EN undefined: multiplies use the 32-cycle iterative path above. No multiplier is inferred.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), start at N -> busy high N+1..N+33; result=0xFFFFFFEB, result_valid pulse only at N+33 (N+1 with FAST_MUL_EN).
- MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD at N+33. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFF at N+1. REMU -> 0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at N+1. REM same operands -> 0.
- Start DIV, then:
  - assert flush at N+10 -> busy=0 at N+11, no result_valid through N+40;
  - start asserted at N+5 with rd_in=9 is ignored, and rd_out of the original op is unchanged.
- reset_n=0 at N+20 of a MUL -> busy=0, result=0 after that edge; a new MUL issued after release completes correctly at its N'+33.
